// File: rtl/life_pkg.sv
// Shared constants and types for the Game of Life seed loader.
// Holds board geometry, built-in patterns, mode and state encodings.
package life_pkg;

    localparam int BOARD_W = 8;
    localparam int BOARD_H = 8;
    localparam int CELLS   = BOARD_W * BOARD_H;

    // Built-in boards, bit i = cell i, row-major.
    localparam logic [63:0] PAT_UW     = 64'h50A8_8888_0609_0909;
    localparam logic [63:0] PAT_GLIDER = 64'h0000_0000_0007_0402;

    // Galois LFSR feedback mask, right-shifting.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        MODE_UW     = 2'd0,
        MODE_GLIDER = 2'd1,
        MODE_RANDOM = 2'd2,
        MODE_SERIAL = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GATHER     = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_OFFER      = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus a registered
// rising-edge pulse.
// Ports: clk, rst_n, pin (async in), level (synced), rise (1-cycle pulse).
module pin_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              prev;

    // A pin rise in cycle 0 reaches the top sync flop in cycle 2 and
    // shows up as a registered pulse in cycle 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], pin};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
        end
    end

    assign level = sync[STAGES-1];

endmodule

// File: rtl/life_seed_loader.sv
// Seed board source for the Life engine: builds a 64-cell board from a
// built-in pattern, LFSR fill or serial pins, and offers it on a frame edge.
// Ports: clk, rst_n, mode, load_req, ser_clk, ser_data, ser_latch,
//        frame_tick, seed_valid/seed_ready/seed_data, busy, frame_err.
module life_seed_loader #(
    parameter int          CELLS       = 64,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             load_req,
    input  logic             ser_clk,
    input  logic             ser_data,
    input  logic             ser_latch,
    input  logic             frame_tick,
    output logic             seed_valid,
    input  logic             seed_ready,
    output logic [CELLS-1:0] seed_data,
    output logic             busy,
    output logic             frame_err
);

    import life_pkg::*;

    localparam logic [6:0] CNT_FULL = 7'(CELLS);

    logic load_rise;
    logic ser_clk_rise;
    logic ser_data_lvl;
    logic latch_rise;

    logic load_lvl_unused;
    logic ser_clk_lvl_unused;
    logic ser_data_rise_unused;
    logic latch_lvl_unused;

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_load (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (load_req),
        .level (load_lvl_unused),
        .rise  (load_rise)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ser_clk),
        .level (ser_clk_lvl_unused),
        .rise  (ser_clk_rise)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sdat (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ser_data),
        .level (ser_data_lvl),
        .rise  (ser_data_rise_unused)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ser_latch),
        .level (latch_lvl_unused),
        .rise  (latch_rise)
    );

    // Free-running LFSR; the random fill samples whatever phase it is in.
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Serial shifter runs in every state so a board can be shifted in
    // while a previous one is still being offered.
    logic [CELLS-1:0] shift_reg;
    logic [6:0]       bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (ser_clk_rise) begin
            shift_reg <= {shift_reg[CELLS-2:0], ser_data_lvl};
        end
    end

    // A latch edge always restarts the count, even when it is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (latch_rise) begin
            bit_cnt <= '0;
        end else if (ser_clk_rise && bit_cnt != CNT_FULL) begin
            bit_cnt <= bit_cnt + 7'd1;
        end
    end

    state_t           state;
    mode_t            lmode;
    logic [CELLS-1:0] stage;
    logic [5:0]       gcnt;
    logic             armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lmode      <= MODE_UW;
            stage      <= '0;
            gcnt       <= '0;
            armed      <= 1'b0;
            seed_valid <= 1'b0;
            seed_data  <= '0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (load_rise && mode != MODE_SERIAL) begin
                        lmode <= mode_t'(mode);
                        gcnt  <= '0;
                        state <= ST_GATHER;
                        busy  <= 1'b1;
                    end else if (latch_rise && mode == MODE_SERIAL) begin
                        if (bit_cnt == CNT_FULL) begin
                            stage <= shift_reg;
                            armed <= 1'b0;
                            state <= ST_WAIT_FRAME;
                            busy  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                ST_GATHER: begin
                    unique case (lmode)
                        MODE_UW: begin
                            stage <= PAT_UW;
                            armed <= 1'b0;
                            state <= ST_WAIT_FRAME;
                        end
                        MODE_GLIDER: begin
                            stage <= PAT_GLIDER;
                            armed <= 1'b0;
                            state <= ST_WAIT_FRAME;
                        end
                        default: begin
                            // First sampled bit ends up in the top cell.
                            stage <= {stage[CELLS-2:0], lfsr[0]};
                            gcnt  <= gcnt + 6'd1;
                            if (gcnt == 6'd63) begin
                                armed <= 1'b0;
                                state <= ST_WAIT_FRAME;
                            end
                        end
                    endcase
                end
                ST_WAIT_FRAME: begin
                    // A tick in the entry cycle may belong to a frame that
                    // already started, so only later ticks count.
                    armed <= 1'b1;
                    if (frame_tick && armed) begin
                        seed_data  <= stage;
                        seed_valid <= 1'b1;
                        state      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (seed_ready) begin
                        seed_valid <= 1'b0;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/life_seed_loader.md
Name: life_seed_loader

Overview:
- Upstream stage of the Game of Life engine. Produces a complete 64-cell (8x8) seed board and hands it to the engine over a valid/ready handshake.
- Seed source is one of: built-in "UW" pattern, glider pattern, LFSR pseudo-random fill, or a board shifted in serially on uio pins.
- Handoff is held back until a frame boundary (frame_tick from the sync generator), so the displayed board never changes mid-frame.

Parameters:
- CELLS, 64, board size in cells; bit i = cell i, row-major, row = i/8, col = i%8.
- SYNC_STAGES, 2, synchroniser depth for asynchronous pin inputs.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- mode, in, 2, seed source, sampled when a load starts: 0 = UW, 1 = GLIDER, 2 = RANDOM, 3 = SERIAL.
- load_req, in, 1, asynchronous pin; its rising edge starts a load in modes 0-2.
- ser_clk, in, 1, asynchronous pin; serial bit clock.
- ser_data, in, 1, asynchronous pin; serial data bit.
- ser_latch, in, 1, asynchronous pin; its rising edge commits the serial board in mode 3.
- frame_tick, in, 1, one-cycle pulse synchronous to clk, asserted at each vsync start.
- seed_valid, out, 1, seed_data holds a board awaiting acceptance.
- seed_ready, in, 1, engine accepts the board.
- seed_data, out, 64, board; bit i = cell i.
- busy, out, 1, high in every state except IDLE.
- frame_err, out, 1, one-cycle pulse when a serial latch arrives with fewer than 64 bits received.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; seed_valid = 0, seed_data = 0, busy = 0, frame_err = 0.
  - shift_reg = 0, bit_cnt = 0, lfsr = LFSR_SEED, all synchroniser and edge flops = 0.
- Pin inputs (load_req, ser_clk, ser_data, ser_latch):
  - each goes through SYNC_STAGES flops plus an edge register.
  - a pin rise at cycle 0 gives an edge pulse at cycle 3.
- LFSR: 16-bit Galois, taps mask 16'hB400, right shift; advances every clk cycle regardless of state.
- Serial shifter runs in all states and modes:
  - on each synced ser_clk rising edge: shift_reg <= {shift_reg[62:0], ser_data_synced}.
  - bit_cnt increments and saturates at 64.
  - the first bit of a 64-bit burst ends in bit 63.
  - more than 64 bits: the last 64 are kept.
- States:
  - IDLE:
    - load_req edge with mode 0-2 -> latch mode, go to GATHER.
    - ser_latch edge with mode 3:
      - bit_cnt == 64: stage <= shift_reg, go to WAIT_FRAME.
      - otherwise: pulse frame_err, stay IDLE.
    - bit_cnt <= 0 on any ser_latch edge, in every state.
  - GATHER:
    - mode 0: stage <= 64'h50A8_8888_0609_0909 (1 cycle).
    - mode 1: stage <= 64'h0000_0000_0007_0402 (1 cycle).
    - mode 2: stage <= {stage[62:0], lfsr[0]} for 64 cycles (6-bit counter), then leave.
    - exit to WAIT_FRAME.
  - WAIT_FRAME:
    - on frame_tick: seed_data <= stage, seed_valid <= 1, go to OFFER.
    - a tick in the cycle the state is entered is not honoured.
  - OFFER:
    - seed_valid and seed_data held stable until seed_ready.
    - on the cycle valid && ready: seed_valid <= 0 next edge, go to IDLE.
    - seed_data keeps its last value after handoff.
- Ignored events:
  - load_req or ser_latch edges outside IDLE (ser_latch still clears bit_cnt).
  - seed_ready while seed_valid = 0.
  - a mode change after a load starts has no effect on that load.
- Latency, mode 0/1: pin rise at cycle 0 -> GATHER at cycle 4 -> WAIT_FRAME at cycle 5 -> seed_valid rises the cycle after the first frame_tick seen in WAIT_FRAME.

Decomposition:
- Shared package life_pkg holds:
  - BOARD_W = 8, BOARD_H = 8, CELLS = 64.
  - PAT_UW, PAT_GLIDER.
  - mode encodings MODE_UW, MODE_GLIDER, MODE_RANDOM, MODE_SERIAL.
  - state encodings.
  - LFSR_TAPS = 16'hB400.
- One sub-module, pin_sync_edge: SYNC_STAGES-flop synchroniser with a rising-edge pulse output. Instantiated four times (load_req, ser_clk, ser_data, ser_latch); only the level output is used for ser_data.

Test Plan:
- Reset, mode = 0, pulse load_req, frame_tick 20 cycles later, seed_ready = 1 -> seed_valid rises one cycle after the tick with seed_data = 64'h50A8_8888_0609_0909; valid lasts 1 cycle; busy falls to 0.
- Mode = 1, seed_ready = 0 for 10 cycles after valid -> seed_data = 64'h0000_0000_0007_0402 held stable; valid stays 1 until ready, then drops next cycle.
- Mode = 2 from reset, load_req, tick long after GATHER -> seed_data matches a reference-model LFSR (seed 16'hACE1, taps B400) over the 64 GATHER cycles; result is non-zero and reproducible across two resets.
- Mode = 3, shift 64 bits 1,0,0,... then ser_latch, then frame_tick -> seed_data = 64'h8000_0000_0000_0000. Repeat with 10 bits only -> frame_err pulses once, seed_valid stays 0, bit_cnt = 0.
- During OFFER, pulse load_req and ser_latch -> ignored; the following load proceeds normally after the handshake completes.
- Drop rst_n mid-GATHER (mode 2) and mid-OFFER -> all outputs go to 0 immediately without a clock edge; state is IDLE after release.
